// File: rtl/key_filter_multi.sv
// -----------------------------------------------------------------------------
// key_filter_multi
//
// N-channel pushbutton conditioner. Each channel debounces one synchronised
// key level and produces:
//   - a one-cycle PRESS pulse for each accepted press,
//   - a one-cycle RELEASE pulse for each accepted release,
//   - the debounced LEVEL.
// Each channel also enforces a minimum spacing between accepted presses
// (holdoff). The channels are fully independent, so several PRESS bits can be
// set in the same cycle.
//
// Optional feature: define KEY_AUTOREPEAT_EN to enable auto-repeat while a key
// is held. The first repeat PRESS comes REPEAT_DLY_CYC cycles after the
// accepted press, and later ones every REPEAT_CYC cycles. LEVEL stays high and
// no RELEASE is issued. When the macro is undefined, the repeat counter and
// its parameters do not exist.
//
// Ports
//   CLK      in   1       system clock, all logic on posedge
//   RST      in   1       synchronous reset, active-high
//   IN       in   N_KEYS  synchronised raw key levels, 1 = pressed
//   PRESS    out  N_KEYS  one-cycle pulse per accepted press (and per repeat)
//   RELEASE  out  N_KEYS  one-cycle pulse per accepted release
//   LEVEL    out  N_KEYS  debounced key state
//   ANY      out  1       OR of PRESS, same cycle as PRESS
//
// All outputs are registered. Every counter is CNT_W bits wide. Each counter
// is compared before it is loaded, so it never wraps. Counts that do not fit
// in CNT_W bits are a parameter error.
// -----------------------------------------------------------------------------
module key_filter_multi #(
  parameter int unsigned N_KEYS         = 4,
  parameter int unsigned CNT_W          = 25,
  parameter int unsigned DEBOUNCE_CYC   = 250000,
  parameter int unsigned HOLDOFF_CYC    = 5000000
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY_CYC = 25000000,
  parameter int unsigned REPEAT_CYC     = 5000000
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] IN,
  output logic [N_KEYS-1:0] PRESS,
  output logic [N_KEYS-1:0] RELEASE,
  output logic [N_KEYS-1:0] LEVEL,
  output logic              ANY
);

  typedef enum logic [1:0] {
    StIdle,
    StDebOn,
    StHeld,
    StDebOff
  } key_state_e;

  // The debounce counter holds the number of consecutive qualifying samples
  // seen so far. An edge is accepted on the sample that brings the count to
  // DEBOUNCE_CYC, which is when the stored count equals DebLast.
  localparam logic [CNT_W-1:0] DebLast     = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HoldoffLoad =
      (HOLDOFF_CYC == 0) ? '0 : CNT_W'(HOLDOFF_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RepDlyLoad  =
      (REPEAT_DLY_CYC == 0) ? '0 : CNT_W'(REPEAT_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] RepLoad     =
      (REPEAT_CYC == 0) ? '0 : CNT_W'(REPEAT_CYC - 1);
`endif

  // Per-channel press events, collected here so ANY can be registered in the
  // same cycle as the PRESS bits.
  logic [N_KEYS-1:0] press_vec;
  logic              any_d, any_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_state_e       state_d, state_q;
    logic [CNT_W-1:0] deb_d, deb_q;
    logic [CNT_W-1:0] hold_d, hold_q;
    logic             accept;
    logic             press_ev;
    logic             release_ev;
    logic             level_d;
    logic             press_q, release_q, level_q;
`ifdef KEY_AUTOREPEAT_EN
    logic [CNT_W-1:0] rep_d, rep_q;
    logic             repeat_ev;
`endif

    always_comb begin
      state_d    = state_q;
      deb_d      = deb_q;
      // The holdoff counter runs in every state and saturates at zero.
      hold_d     = (hold_q != '0) ? hold_q - CntOne : '0;
      accept     = 1'b0;
      release_ev = 1'b0;

      unique case (state_q)
        StIdle: begin
          deb_d = '0;
          // A press that arrives while holdoff is still running is ignored.
          if (IN[k] && (hold_q == '0)) begin
            if (DebLast == '0) begin
              state_d = StHeld;
              accept  = 1'b1;
            end else begin
              state_d = StDebOn;
              deb_d   = CntOne;
            end
          end
        end

        StDebOn: begin
          if (IN[k]) begin
            if (deb_q == DebLast) begin
              state_d = StHeld;
              deb_d   = '0;
              accept  = 1'b1;
            end else begin
              deb_d = deb_q + CntOne;
            end
          end else begin
            state_d = StIdle;
            deb_d   = '0;
          end
        end

        StHeld: begin
          deb_d = '0;
          if (!IN[k]) begin
            if (DebLast == '0) begin
              state_d    = StIdle;
              release_ev = 1'b1;
            end else begin
              state_d = StDebOff;
              deb_d   = CntOne;
            end
          end
        end

        StDebOff: begin
          if (!IN[k]) begin
            if (deb_q == DebLast) begin
              state_d    = StIdle;
              deb_d      = '0;
              release_ev = 1'b1;
            end else begin
              deb_d = deb_q + CntOne;
            end
          end else begin
            // A low glitch shorter than the debounce window is filtered out.
            state_d = StHeld;
            deb_d   = '0;
          end
        end

        default: begin
          state_d = StIdle;
          deb_d   = '0;
        end
      endcase

`ifdef KEY_AUTOREPEAT_EN
      rep_d     = '0;
      repeat_ev = 1'b0;
      if (accept) begin
        rep_d = RepDlyLoad;
      end else if (((state_q == StHeld) || (state_q == StDebOff)) && !release_ev) begin
        if (rep_q == '0) begin
          repeat_ev = 1'b1;
          rep_d     = RepLoad;
        end else begin
          rep_d = rep_q - CntOne;
        end
      end
      press_ev = accept | repeat_ev;
`else
      press_ev = accept;
`endif

      // Every PRESS, including a repeat, restarts the minimum-spacing window.
      if (press_ev) begin
        hold_d = HoldoffLoad;
      end

      level_d = (state_d == StHeld) || (state_d == StDebOff);
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q   <= StIdle;
        deb_q     <= '0;
        hold_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        level_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        deb_q     <= deb_d;
        hold_q    <= hold_d;
        press_q   <= press_ev;
        release_q <= release_ev;
        level_q   <= level_d;
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge CLK) begin
      if (RST) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_d;
      end
    end
`endif

    assign press_vec[k] = press_ev;
    assign PRESS[k]     = press_q;
    assign RELEASE[k]   = release_q;
    assign LEVEL[k]     = level_q;
  end

  always_comb begin
    any_d = |press_vec;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign ANY = any_q;

endmodule

// File: tb/tb_key_filter_multi.sv
// -----------------------------------------------------------------------------
// tb_key_filter_multi
//
// Directed bench for key_filter_multi with N_KEYS=2, DEBOUNCE_CYC=4,
// HOLDOFF_CYC=20, REPEAT_DLY_CYC=30 and REPEAT_CYC=10.
//
// The stimulus script pushes the expected pulse events, including the cycle
// each one should appear in, into a queue. A monitor running on negedge pops
// one entry each time the DUT shows PRESS, RELEASE or ANY activity and
// compares it with what the DUT presents. Quiet-cycle state (reset values,
// LEVEL during a glitch) is checked directly from the script.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_filter_multi;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] IN;
  logic [1:0] PRESS;
  logic [1:0] RELEASE;
  logic [1:0] LEVEL;
  logic       ANY;

  always #5 CLK = ~CLK;

  key_filter_multi #(
    .N_KEYS        (2),
    .CNT_W         (8),
    .DEBOUNCE_CYC  (4),
    .HOLDOFF_CYC   (20)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DLY_CYC(30),
    .REPEAT_CYC    (10)
`endif
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .IN     (IN),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .LEVEL  (LEVEL),
    .ANY    (ANY)
  );

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lvl;
    logic       any;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  vectors     = 0;
  int  miscompares = 0;
  int  cyc         = 0;

  // Count of posedges seen so far.
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard monitor: every output event must match the oldest expectation.
  always @(negedge CLK) begin
    if (((PRESS | RELEASE) != 2'b00) || (ANY !== 1'b0)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got press=%b release=%b level=%b any=%b, required no event",
                 cyc, PRESS, RELEASE, LEVEL, ANY);
      end else begin
        mon_e = exp_q.pop_front();
        if ((mon_e.cyc != cyc) || (PRESS !== mon_e.press) || (RELEASE !== mon_e.rel) ||
            (LEVEL !== mon_e.lvl) || (ANY !== mon_e.any)) begin
          miscompares++;
          $display("FAIL event cyc=%0d press=%b release=%b level=%b any=%b, required cyc=%0d press=%b release=%b level=%b any=%b",
                   cyc, PRESS, RELEASE, LEVEL, ANY,
                   mon_e.cyc, mon_e.press, mon_e.rel, mon_e.lvl, mon_e.any);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                           input logic [1:0] l, input logic a);
    ev_t e;
    e.cyc   = at;
    e.press = p;
    e.rel   = r;
    e.lvl   = l;
    e.any   = a;
    exp_q.push_back(e);
  endtask

  // Direct check of the whole output bundle {PRESS, RELEASE, LEVEL, ANY}.
  task automatic check(input string name, input logic [6:0] want);
    logic [6:0] got;
    got = {PRESS, RELEASE, LEVEL, ANY};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got {press,release,level,any}=%b required %b",
               name, cyc, got, want);
    end
  endtask

  initial begin
    int c;
    int p;
    int t;
    int u;
    int t0;

    // 1. Reset held with both keys pressed, then the first debounce after reset.
    RST = 1'b1;
    IN  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("reset_outputs", 7'b00_00_00_0);
    end
    RST = 1'b0;
    c   = cyc;
    expect_ev(c + 4, 2'b11, 2'b00, 2'b11, 1'b1);
    tick(1);
    check("no_pulse_after_reset", 7'b00_00_00_0);
    tick(5);
    IN = 2'b00;
    c  = cyc;
    expect_ev(c + 4, 2'b00, 2'b11, 2'b00, 1'b0);
    tick(5);
    check("both_released_idle", 7'b00_00_00_0);

    // 2. Bouncy press on key 0: 3 high, 1 low, then held.
    tick(25);
    IN = 2'b01;
    tick(3);
    IN = 2'b00;
    tick(1);
    IN = 2'b01;
    p  = cyc + 4;
    expect_ev(p, 2'b01, 2'b00, 2'b01, 1'b1);
    tick(5);
    check("level0_held", 7'b00_00_01_0);

    // 3. Release after 6 cycles, immediate re-press is held off until 20 after.
    tick(5);
    IN = 2'b00;
    expect_ev(p + 10, 2'b00, 2'b01, 2'b00, 1'b0);
    tick(4);
    IN = 2'b01;
    expect_ev(p + 23, 2'b01, 2'b00, 2'b01, 1'b1);
    tick(15);
    IN = 2'b00;
    expect_ev(p + 29, 2'b00, 2'b01, 2'b00, 1'b0);
    tick(5);
    check("key0_idle_after_repress", 7'b00_00_00_0);

    // 4. Two-cycle low glitch on held key 1 is filtered.
    tick(25);
    IN = 2'b10;
    t  = cyc;
    expect_ev(t + 4, 2'b10, 2'b00, 2'b10, 1'b1);
    tick(6);
    IN = 2'b00;
    tick(1);
    check("glitch_level1_a", 7'b00_00_10_0);
    tick(1);
    check("glitch_level1_b", 7'b00_00_10_0);
    IN = 2'b10;
    tick(1);
    check("glitch_level1_c", 7'b00_00_10_0);
    tick(1);
    check("glitch_level1_d", 7'b00_00_10_0);
    tick(2);
    IN = 2'b00;
    expect_ev(t + 16, 2'b00, 2'b10, 2'b00, 1'b0);
    tick(5);
    check("key1_idle", 7'b00_00_00_0);

    // 6. Reset pulse during debounce (count 2) aborts it; a fresh 4-sample debounce follows.
    tick(25);
    IN = 2'b01;
    u  = cyc;
    tick(2);
    RST = 1'b1;
    tick(1);
    check("reset_aborts_debounce", 7'b00_00_00_0);
    RST = 1'b0;
    expect_ev(u + 7, 2'b01, 2'b00, 2'b01, 1'b1);
    tick(6);
    IN = 2'b00;
    expect_ev(u + 13, 2'b00, 2'b01, 2'b00, 1'b0);
    tick(5);

    // 5. Key 0 held for a long time: auto-repeat only when the feature is built in.
    tick(25);
    IN = 2'b01;
    t0 = cyc + 4;
    expect_ev(t0, 2'b01, 2'b00, 2'b01, 1'b1);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 3; k <= 7; k++) begin
      expect_ev(t0 + 10 * k, 2'b01, 2'b00, 2'b01, 1'b1);
    end
`endif
    tick(79);
    IN = 2'b00;
    expect_ev(t0 + 79, 2'b00, 2'b01, 2'b00, 1'b0);
    tick(8);
    check("final_idle", 7'b00_00_00_0);

    // Every expected event must have been seen.
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events got %0d outstanding, required 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
